// File: rtl/conv_encoder_punct_pkg.sv
// Shared definitions for the punctured convolutional encoder:
// rate codes, default code parameters and puncture period table.
package conv_encoder_punct_pkg;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    localparam int         DEF_K  = 7;
    localparam logic [6:0] DEF_G0 = 7'o133;
    localparam logic [6:0] DEF_G1 = 7'o171;

    // Indexed by rate code; the reserved code behaves as rate 1/2.
    localparam logic [1:0] PUNCT_PERIOD [4] = '{2'd1, 2'd2, 2'd3, 2'd1};

    function automatic logic [1:0] punct_period(input rate_t r);
        return PUNCT_PERIOD[r];
    endfunction

endpackage

// File: rtl/conv_encoder_punct_parity.sv
// Masked XOR-reduce of the K-bit encoding vector against one
// generator polynomial.
module conv_parity #(
    parameter int         K = 7,
    parameter logic [K-1:0] G = '0
) (
    input  logic [K-1:0] v,
    output logic         p
);

    assign p = ^(v & G);

endmodule

// File: rtl/conv_encoder_punct.sv
// Rate 1/2 convolutional encoder with 2/3 and 3/4 puncturing and
// a two-entry serialising output buffer.
module conv_encoder_punct
    import conv_encoder_punct_pkg::*;
#(
    parameter int           K  = DEF_K,
    parameter logic [K-1:0] G0 = DEF_G0,
    parameter logic [K-1:0] G1 = DEF_G1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_sof,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] rate,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready
);

    logic [K-2:0] sr_q, sr_d, sr_eff;
    logic [1:0]   phase_q, phase_d, phase_eff, phase_inc;
    rate_t        rate_q, rate_d, rate_eff, rate_n;
    occ_t         occ_q, occ_d;
    logic [1:0]   buf_q, buf_d;
    logic [K-1:0] v;
    logic         code_a, code_b;
    logic         keep_a, keep_b;
    logic         accept, consume;

    assign in_ready  = (occ_q == OCC_EMPTY);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_bit   = buf_q[0];
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // A frame start encodes against an empty history at phase 0.
    assign sr_eff    = in_sof ? '0 : sr_q;
    assign phase_eff = in_sof ? 2'd0 : phase_q;
    assign phase_inc = phase_eff + 2'd1;
    assign rate_n    = (rate_t'(rate) == RATE_RSVD) ? RATE_1_2 : rate_t'(rate);
    assign rate_eff  = (phase_eff == 2'd0) ? rate_n : rate_q;

    always_comb begin
        v      = '0;
        v[K-1] = in_bit;
        for (int i = 0; i < K - 1; i++) begin
            v[K-2-i] = sr_eff[i];
        end
    end

    conv_parity #(.K(K), .G(G0)) u_par_a (.v(v), .p(code_a));
    conv_parity #(.K(K), .G(G1)) u_par_b (.v(v), .p(code_b));

    always_comb begin
        keep_a = 1'b1;
        keep_b = 1'b1;
        unique case (rate_eff)
            RATE_2_3: keep_b = (phase_eff != 2'd1);
            RATE_3_4: begin
                keep_b = (phase_eff != 2'd1);
                keep_a = (phase_eff != 2'd2);
            end
            default: ;
        endcase
    end

    always_comb begin
        sr_d    = sr_q;
        phase_d = phase_q;
        rate_d  = rate_q;
        occ_d   = occ_q;
        buf_d   = buf_q;
        if (accept) begin
            sr_d    = {sr_eff[K-3:0], in_bit};
            phase_d = (phase_inc == punct_period(rate_eff)) ? 2'd0 : phase_inc;
            if (phase_eff == 2'd0) begin
                rate_d = rate_n;
            end
            if (keep_a && keep_b) begin
                buf_d = {code_b, code_a};
                occ_d = OCC_TWO;
            end else begin
                buf_d = {1'b0, keep_a ? code_a : code_b};
                occ_d = OCC_ONE;
            end
        end else if (consume) begin
            buf_d = {1'b0, buf_q[1]};
            occ_d = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            phase_q <= 2'd0;
            rate_q  <= RATE_1_2;
            occ_q   <= OCC_EMPTY;
            buf_q   <= 2'b00;
        end else begin
            sr_q    <= sr_d;
            phase_q <= phase_d;
            rate_q  <= rate_d;
            occ_q   <= occ_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: impulse streams per rate,
// puncture restarts, backpressure, rate change and reset recovery.
module tb_conv_encoder_punct;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_bit = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [1:0] rate = 2'b00;
    logic       in_ready, out_bit, out_valid;

    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    logic obs[$];

    conv_encoder_punct dut (
        .clk(clk), .rst(rst),
        .in_bit(in_bit), .in_sof(in_sof),
        .in_valid(in_valid), .in_ready(in_ready),
        .rate(rate),
        .out_bit(out_bit), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) obs.push_back(out_bit);
    end

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs.delete();
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send_bit(input logic b, input logic sof, input logic [1:0] r);
        int n;
        in_bit   = b;
        in_sof   = sof;
        rate     = r;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (out_valid) begin
            errors++;
            $display("FAIL drain_timeout got out_valid=1 want 0");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got %b want 1", in_ready);
        end
        vectors++;
        if (out_bit !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_bit got %b want 0", out_bit);
        end
    endtask

    task automatic test_rate12_impulse();
        logic exp[$] = '{1,1, 0,1, 1,1, 1,1, 0,0, 1,0, 1,1};
        int t0;
        apply_reset();
        t0 = cyc;
        send_bit(1'b1, 1'b1, 2'b00);
        repeat (6) send_bit(1'b0, 1'b0, 2'b00);
        vectors++;
        if (cyc - t0 != 19) begin
            errors++;
            $display("FAIL r12_throughput got %0d cycles want 19", cyc - t0);
        end
        drain();
        vectors++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL r12_len got %0d want %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) begin
            vectors++;
            if (obs.size() <= i || obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL r12_bit%0d got %b want %b", i,
                         (obs.size() > i) ? obs[i] : 1'bx, exp[i]);
            end
        end
    endtask

    task automatic test_rate23();
        logic exp[$] = '{1,1, 0, 0,0};
        apply_reset();
        send_bit(1'b1, 1'b1, 2'b01);
        send_bit(1'b0, 1'b0, 2'b01);
        send_bit(1'b1, 1'b0, 2'b01);
        drain();
        vectors++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL r23_len got %0d want %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) begin
            vectors++;
            if (obs.size() <= i || obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL r23_bit%0d got %b want %b", i,
                         (obs.size() > i) ? obs[i] : 1'bx, exp[i]);
            end
        end
    endtask

    task automatic test_rate34();
        logic exp[$] = '{1,1, 0, 1, 1,1};
        apply_reset();
        send_bit(1'b1, 1'b1, 2'b10);
        repeat (3) send_bit(1'b0, 1'b0, 2'b10);
        drain();
        vectors++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL r34_len got %0d want %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) begin
            vectors++;
            if (obs.size() <= i || obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL r34_bit%0d got %b want %b", i,
                         (obs.size() > i) ? obs[i] : 1'bx, exp[i]);
            end
        end
    endtask

    task automatic test_rate_reserved();
        logic exp[$] = '{1,1, 0,1};
        apply_reset();
        send_bit(1'b1, 1'b1, 2'b11);
        send_bit(1'b0, 1'b0, 2'b11);
        drain();
        vectors++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL rsvd_len got %0d want %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) begin
            vectors++;
            if (obs.size() <= i || obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL rsvd_bit%0d got %b want %b", i,
                         (obs.size() > i) ? obs[i] : 1'bx, exp[i]);
            end
        end
    endtask

    task automatic test_sof_restart();
        logic exp[$] = '{1,1, 1,1};
        apply_reset();
        send_bit(1'b1, 1'b1, 2'b01);
        send_bit(1'b1, 1'b1, 2'b01);
        drain();
        vectors++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL sof_len got %0d want %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) begin
            vectors++;
            if (obs.size() <= i || obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL sof_bit%0d got %b want %b", i,
                         (obs.size() > i) ? obs[i] : 1'bx, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic exp[$] = '{1,1, 0,1, 1,1, 1,1, 0,0, 1,0, 1,1};
        apply_reset();
        out_ready = 1'b0;
        send_bit(1'b1, 1'b1, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_bit !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c%0d got v=%b b=%b want v=1 b=1",
                         c, out_valid, out_bit);
            end
            vectors++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (6) send_bit(1'b0, 1'b0, 2'b00);
        drain();
        vectors++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL bp_len got %0d want %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) begin
            vectors++;
            if (obs.size() <= i || obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_bit%0d got %b want %b", i,
                         (obs.size() > i) ? obs[i] : 1'bx, exp[i]);
            end
        end
    endtask

    task automatic test_rate_change();
        logic exp[$] = '{1,1, 0, 1, 1,1, 0,0};
        apply_reset();
        send_bit(1'b1, 1'b1, 2'b10);
        repeat (4) send_bit(1'b0, 1'b0, 2'b00);
        drain();
        vectors++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL rchg_len got %0d want %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) begin
            vectors++;
            if (obs.size() <= i || obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL rchg_bit%0d got %b want %b", i,
                         (obs.size() > i) ? obs[i] : 1'bx, exp[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic exp[$] = '{1,1, 0,1, 1,1, 1,1, 0,0, 1,0, 1,1};
        apply_reset();
        out_ready = 1'b0;
        send_bit(1'b1, 1'b1, 2'b00);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bit !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got v=%b r=%b b=%b want v=0 r=1 b=0",
                     out_valid, in_ready, out_bit);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs.delete();
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale got out_valid=%b want 0", out_valid);
        end
        @(posedge clk);
        #1;
        send_bit(1'b1, 1'b1, 2'b00);
        repeat (6) send_bit(1'b0, 1'b0, 2'b00);
        drain();
        vectors++;
        if (obs.size() != exp.size()) begin
            errors++;
            $display("FAIL mid_len got %0d want %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) begin
            vectors++;
            if (obs.size() <= i || obs[i] !== exp[i]) begin
                errors++;
                $display("FAIL mid_bit%0d got %b want %b", i,
                         (obs.size() > i) ? obs[i] : 1'bx, exp[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rate12_impulse();
        test_rate23();
        test_rate34();
        test_rate_reserved();
        test_sof_restart();
        test_backpressure();
        test_rate_change();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
